// File: rtl/fp16_align_stage.sv
// Operand-alignment front end of the FP16 add/sub datapath. It orders the two operands
// by magnitude and produces the shifter control word. Two registered stages with backpressure.
module fp16_align_stage #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [EXP_W+MAN_W:0]     i_a,
    input  logic [EXP_W+MAN_W:0]     i_b,
    input  logic                     i_op_sub,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [MAN_W:0]           o_mant_big,
    output logic [MAN_W:0]           o_mant_small,
    output logic [4:0]               o_shift_ctrl,
    output logic [EXP_W-1:0]         o_exp_big,
    output logic                     o_sign_big,
    output logic                     o_eff_sub,
    output logic                     o_swapped,
    output logic [1:0]               o_special
);

    logic [EXP_W-1:0] w_exp_a, w_exp_b, w_eexp_a, w_eexp_b;
    logic [MAN_W:0]   w_sig_a, w_sig_b;
    logic             w_sub_a, w_sub_b, w_max_a, w_max_b;
    logic             w_nan, w_inf, w_zero, w_a_big;
    logic [1:0]       w_special;

    assign w_exp_a  = i_a[MAN_W +: EXP_W];
    assign w_exp_b  = i_b[MAN_W +: EXP_W];
    assign w_sub_a  = (w_exp_a == '0);
    assign w_sub_b  = (w_exp_b == '0);
    assign w_max_a  = &w_exp_a;
    assign w_max_b  = &w_exp_b;
    // Subnormals carry effective exponent 1 with a clear hidden bit.
    assign w_eexp_a = w_sub_a ? EXP_W'(1) : w_exp_a;
    assign w_eexp_b = w_sub_b ? EXP_W'(1) : w_exp_b;
    assign w_sig_a  = {~w_sub_a, i_a[MAN_W-1:0]};
    assign w_sig_b  = {~w_sub_b, i_b[MAN_W-1:0]};

    assign w_nan  = (w_max_a & (|i_a[MAN_W-1:0])) | (w_max_b & (|i_b[MAN_W-1:0]));
    assign w_inf  = (w_max_a & ~(|i_a[MAN_W-1:0])) | (w_max_b & ~(|i_b[MAN_W-1:0]));
    assign w_zero = (w_sub_a & ~(|i_a[MAN_W-1:0])) & (w_sub_b & ~(|i_b[MAN_W-1:0]));

    always_comb begin
        w_special = 2'b00;
        if (w_nan) begin
            w_special = 2'b11;
        end else if (w_inf) begin
            w_special = 2'b10;
        end else if (w_zero) begin
            w_special = 2'b01;
        end
    end

    // Ties on full magnitude keep A as the big operand.
    assign w_a_big = (w_eexp_a > w_eexp_b) || ((w_eexp_a == w_eexp_b) && (w_sig_a >= w_sig_b));

    // Handshake
    logic r_s1_valid, r_s2_valid;
    logic w_s2_free;

    assign w_s2_free   = ~r_s2_valid | i_out_ready;
    assign o_in_ready  = ~r_s1_valid | w_s2_free;
    assign o_out_valid = r_s2_valid;

    // Stage 1: decoded fields and compare result
    logic             r_s1_sign_a, r_s1_sign_b, r_s1_op_sub, r_s1_a_big;
    logic [EXP_W-1:0] r_s1_exp_a, r_s1_exp_b;
    logic [MAN_W:0]   r_s1_sig_a, r_s1_sig_b;
    logic [1:0]       r_s1_special;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_sign_a  <= 1'b0;
            r_s1_sign_b  <= 1'b0;
            r_s1_op_sub  <= 1'b0;
            r_s1_a_big   <= 1'b0;
            r_s1_exp_a   <= '0;
            r_s1_exp_b   <= '0;
            r_s1_sig_a   <= '0;
            r_s1_sig_b   <= '0;
            r_s1_special <= 2'b00;
        end else if (o_in_ready) begin
            r_s1_valid <= i_in_valid;
            if (i_in_valid) begin
                r_s1_sign_a  <= i_a[EXP_W+MAN_W];
                r_s1_sign_b  <= i_b[EXP_W+MAN_W];
                r_s1_op_sub  <= i_op_sub;
                r_s1_a_big   <= w_a_big;
                r_s1_exp_a   <= w_eexp_a;
                r_s1_exp_b   <= w_eexp_b;
                r_s1_sig_a   <= w_sig_a;
                r_s1_sig_b   <= w_sig_b;
                r_s1_special <= w_special;
            end
        end
    end

    // Stage 2 next-state: ordering and shift encoding
    logic [EXP_W-1:0] w_exp_big, w_exp_small, w_diff;
    logic [4:0]       w_shift;

    assign w_exp_big   = r_s1_a_big ? r_s1_exp_a : r_s1_exp_b;
    assign w_exp_small = r_s1_a_big ? r_s1_exp_b : r_s1_exp_a;
    assign w_diff      = w_exp_big - w_exp_small;

    // Shifter stage weights are {flush, 6, 3, 2, 1}.
    always_comb begin
        w_shift = 5'b10000;
        case (w_diff)
            5'd0:    w_shift = 5'b00000;
            5'd1:    w_shift = 5'b00001;
            5'd2:    w_shift = 5'b00010;
            5'd3:    w_shift = 5'b00100;
            5'd4:    w_shift = 5'b00101;
            5'd5:    w_shift = 5'b00110;
            5'd6:    w_shift = 5'b01000;
            5'd7:    w_shift = 5'b01001;
            5'd8:    w_shift = 5'b01010;
            5'd9:    w_shift = 5'b01100;
            5'd10:   w_shift = 5'b01101;
            default: w_shift = 5'b10000;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_s2_valid   <= 1'b0;
            o_mant_big   <= '0;
            o_mant_small <= '0;
            o_shift_ctrl <= 5'b00000;
            o_exp_big    <= '0;
            o_sign_big   <= 1'b0;
            o_eff_sub    <= 1'b0;
            o_swapped    <= 1'b0;
            o_special    <= 2'b00;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                o_mant_big   <= r_s1_a_big ? r_s1_sig_a : r_s1_sig_b;
                o_mant_small <= r_s1_a_big ? r_s1_sig_b : r_s1_sig_a;
                o_shift_ctrl <= w_shift;
                o_exp_big    <= w_exp_big;
                o_sign_big   <= r_s1_a_big ? r_s1_sign_a : (r_s1_sign_b ^ r_s1_op_sub);
                o_eff_sub    <= r_s1_sign_a ^ r_s1_sign_b ^ r_s1_op_sub;
                o_swapped    <= ~r_s1_a_big;
                o_special    <= r_s1_special;
            end
        end
    end

endmodule
